// File: rtl/spi_shift_engine.sv
// SPI master shift engine: frames one word per accept using divider ticks,
// all four CPOL/CPHA modes, MSB first, system-clock domain only.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_clk_in,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int CW = $clog2(2 * DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(2 * DATA_WIDTH - 3);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic                  div_q;
  logic                  tick;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  cs_n_q;
  logic                  rx_valid_q;
  logic [CW-1:0]         edge_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  accept;
  logic                  lead;
  logic                  in_xfer;
  logic                  do_sample;
  logic                  do_shift;

  assign tick    = div_clk_in ^ div_q;
  assign accept  = tx_valid && (state_q == IDLE);
  assign lead    = ~edge_q[0];
  assign in_xfer = (state_q == XFER) && tick;

  // cpha=1 holds the MSB through the first leading edge
  assign do_sample = in_xfer && (lead ^ cpha_q);
  assign do_shift  = in_xfer && (cpha_q ? (lead && edge_q != '0)
                                        : (!lead && edge_q <= LAST_SHIFT));

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (tick && edge_q == LAST) state_d = HOLD;
      HOLD:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    div_q <= div_clk_in;
    if (rst) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sclk_q <= cpol_q;
          if (accept) begin
            tx_sr  <= tx_data;
            cpol_q <= cpol;
            cpha_q <= cpha;
            sclk_q <= cpol;
            edge_q <= '0;
            cs_n_q <= 1'b0;
            mosi_q <= tx_data[DATA_WIDTH-1];
          end
        end
        XFER: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_q     <= 1'b1;
            rx_data_q  <= rx_sr;
            rx_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (do_sample) rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
      if (do_shift) begin
        tx_sr  <= tx_sr << 1;
        mosi_q <= tx_sr[DATA_WIDTH-2];
      end
    end
  end

endmodule
